// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// Byte-lane stores are enabled by defining MEMRESP_BYTE_LANE_EN.
package data_mem_responder_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Word index must fit below DEPTH and the byte offset must be zero.
  function automatic logic addr_err(
    input logic [31:0] a,
    input int unsigned depth
  );
    logic [31:0] widx;
    widx = {2'b00, a[31:2]};
    return (a[1:0] != 2'b00) || (widx >= depth);
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-addressed storage, synchronous write with lane mask, synchronous read.
// Contents are never reset.
module data_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [LANES-1:0]  be,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder with programmable latency.
// Define MEMRESP_BYTE_LANE_EN to add ReqByteEn and lane-masked stores.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
`ifdef MEMRESP_BYTE_LANE_EN
  input  logic [3:0]  ReqByteEn,
`endif
  output logic        RespValid,
  input  logic        RespReady,
  output logic [31:0] RespRData,
  output logic        RespErr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        ld_ok_q;
  logic        commit;
  logic        err;
  logic        we;
  logic        re;
  logic [3:0]  be_w;
  logic [31:0] rdata;

`ifdef MEMRESP_BYTE_LANE_EN
  logic [3:0] be_q;
  assign be_w = be_q;
`else
  assign be_w = 4'hF;
`endif

  assign ReqReady = Reset_L && (state == IDLE);
  assign commit   = (state == WAIT) && (cnt == 4'd0);
  assign err      = addr_err(addr_q, DEPTH);
  assign we       = commit && wr_q && !err;
  assign re       = commit && !wr_q && !err;

  // Read data register is not reset; gate it so stores/errors return 0.
  assign RespRData = ld_ok_q ? rdata : 32'h0;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      wr_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      ld_ok_q   <= 1'b0;
      RespValid <= 1'b0;
      RespErr   <= 1'b0;
`ifdef MEMRESP_BYTE_LANE_EN
      be_q      <= 4'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ReqValid) begin
            wr_q    <= ReqWrite;
            addr_q  <= ReqAddr;
            wdata_q <= ReqWData;
`ifdef MEMRESP_BYTE_LANE_EN
            be_q    <= ReqByteEn;
`endif
            cnt     <= LAT_M1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            RespValid <= 1'b1;
            RespErr   <= err;
            ld_ok_q   <= !wr_q && !err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (RespReady) begin
            state     <= IDLE;
            RespValid <= 1'b0;
            RespErr   <= 1'b0;
            ld_ok_q   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  data_mem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk  (CLK),
    .we   (we),
    .re   (re),
    .be   (be_w),
    .addr (addr_q[AW+1:2]),
    .wdata(wdata_q),
    .rdata(rdata)
  );

endmodule
